// File: rtl/rain_pkg.sv
// Shared types and defaults for the rain sensor conditioning path.
package rain_pkg;

    localparam int DEF_CLK_HZ         = 50_000_000;
    localparam int DEF_SAMPLE_HZ      = 1000;
    localparam int DEF_STABLE_SAMPLES = 20;

    typedef enum logic [2:0] {
        INIT,
        DRY,
        WET_PEND,
        WET,
        DRY_PEND
    } fsm_state_t;

    // Clocks per sample tick; zero signals an unusable sample rate.
    function automatic int calc_div(input int clk_hz, input int sample_hz);
        return (sample_hz > 0) ? (clk_hz / sample_hz) : 0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-clk tick every DIV clocks.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    if (DIV < 2) begin : g_div_check
        $error("tick_prescaler: DIV must be at least 2");
    end

    // The tick is registered off the terminal count so the first one lands DIV clks after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
            tick <= (pcnt == LAST);
        end
    end

endmodule

// File: rtl/rain_sensor_filter.sv
// Synchronises and debounces the active-low rain input into a stable level,
// start/stop event pulses and a saturating rain event counter.
module rain_sensor_filter
    import rain_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int SAMPLE_HZ      = DEF_SAMPLE_HZ,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int EVT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entrada,
    input  logic             clear_events,
    output logic             sample_tick,
    output logic             valid,
    output logic             raining,
    output logic             rain_start,
    output logic             rain_stop,
    output logic [EVT_W-1:0] rain_events
);

    localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
    localparam logic [7:0] STABLE_N = 8'(STABLE_SAMPLES);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    if (DIV < 2) begin : g_div_check
        $error("rain_sensor_filter: CLK_HZ/SAMPLE_HZ must be at least 2");
    end
    if (STABLE_SAMPLES < 1 || STABLE_SAMPLES > 255) begin : g_stable_check
        $error("rain_sensor_filter: STABLE_SAMPLES must be within 1..255");
    end

    logic       sync1;
    logic       s_sync;
    logic       smp;
    fsm_state_t state, state_next;
    logic [7:0] scnt, scnt_next, cnt_inc;
    logic       last_smp, last_next;
    logic       valid_next, raining_next, start_next, stop_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            s_sync <= 1'b1;
        end else begin
            sync1  <= entrada;
            s_sync <= sync1;
        end
    end

    assign smp = ~s_sync;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (sample_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            scnt       <= '0;
            last_smp   <= 1'b0;
            valid      <= 1'b0;
            raining    <= 1'b0;
            rain_start <= 1'b0;
            rain_stop  <= 1'b0;
        end else begin
            state      <= state_next;
            scnt       <= scnt_next;
            last_smp   <= last_next;
            valid      <= valid_next;
            raining    <= raining_next;
            rain_start <= start_next;
            rain_stop  <= stop_next;
        end
    end

    // The first decision out of INIT only publishes the level; pulses mark later changes.
    always_comb begin
        state_next   = state;
        scnt_next    = scnt;
        last_next    = last_smp;
        valid_next   = valid;
        raining_next = raining;
        start_next   = 1'b0;
        stop_next    = 1'b0;
        cnt_inc      = scnt + 8'd1;
        if (sample_tick) begin
            case (state)
                INIT: begin
                    last_next = smp;
                    scnt_next = (scnt != 8'd0 && smp == last_smp) ? cnt_inc : 8'd1;
                    if (scnt_next == STABLE_N) begin
                        state_next   = smp ? WET : DRY;
                        valid_next   = 1'b1;
                        raining_next = smp;
                        scnt_next    = 8'd0;
                    end
                end
                DRY: begin
                    if (smp) begin
                        if (STABLE_N == 8'd1) begin
                            state_next   = WET;
                            raining_next = 1'b1;
                            start_next   = 1'b1;
                        end else begin
                            state_next = WET_PEND;
                            scnt_next  = 8'd1;
                        end
                    end
                end
                WET_PEND: begin
                    if (smp) begin
                        if (cnt_inc == STABLE_N) begin
                            state_next   = WET;
                            raining_next = 1'b1;
                            start_next   = 1'b1;
                            scnt_next    = 8'd0;
                        end else begin
                            scnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = DRY;
                        scnt_next  = 8'd0;
                    end
                end
                WET: begin
                    if (!smp) begin
                        if (STABLE_N == 8'd1) begin
                            state_next   = DRY;
                            raining_next = 1'b0;
                            stop_next    = 1'b1;
                        end else begin
                            state_next = DRY_PEND;
                            scnt_next  = 8'd1;
                        end
                    end
                end
                DRY_PEND: begin
                    if (!smp) begin
                        if (cnt_inc == STABLE_N) begin
                            state_next   = DRY;
                            raining_next = 1'b0;
                            stop_next    = 1'b1;
                            scnt_next    = 8'd0;
                        end else begin
                            scnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = WET;
                        scnt_next  = 8'd0;
                    end
                end
                default: begin
                    state_next = INIT;
                    scnt_next  = 8'd0;
                end
            endcase
        end
    end

    // Clear takes priority, then a coincident start still counts as the first event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rain_events <= '0;
        end else if (clear_events) begin
            rain_events <= rain_start ? EVT_W'(1) : '0;
        end else if (rain_start && rain_events != EVT_MAX) begin
            rain_events <= rain_events + 1'b1;
        end
    end

endmodule
